// File: rtl/key_event_ctrl_if.sv
// Bundle of the key-event controller signals between the key debouncer / switch
// bank / CPU read path and the controller itself.
//   key_db    : debounced key level (synchronous to clk)
//   sw_i      : switch bank, captured on event cycles
//   rd_i      : one-cycle CPU read strobe
//   event_o   : one-cycle pulse per press or repeat event
//   press_o   : one-cycle pulse on the initial press only
//   long_o    : high while auto-repeating
//   data_o    : switch value captured at the last event
//   valid_o   : data_o holds unread data
//   overrun_o : sticky, an event overwrote unread data
// master drives the inputs and observes the outputs; slave is the controller.
interface key_event_ctrl_if #(
  parameter int DATA_W = 16
) ();
  logic              key_db;
  logic [DATA_W-1:0] sw_i;
  logic              rd_i;
  logic              event_o;
  logic              press_o;
  logic              long_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              overrun_o;

  modport master (
    output key_db, sw_i, rd_i,
    input  event_o, press_o, long_o, data_o, valid_o, overrun_o
  );

  modport slave (
    input  key_db, sw_i, rd_i,
    output event_o, press_o, long_o, data_o, valid_o, overrun_o
  );
endinterface

// File: rtl/key_event_ctrl.sv
// Turns the debounced key level into CPU-visible input events: a press event
// on the rising edge, then auto-repeat events after HOLD_CYC cycles held,
// every REPEAT_CYC cycles. Each event captures the switch bank into data_o
// with a valid/read handshake and a sticky overrun flag.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : key_event_ctrl_if.slave (key_db, sw_i, rd_i in; event_o, press_o,
//         long_o, data_o, valid_o, overrun_o out)
module key_event_ctrl #(
  parameter int DATA_W     = 16,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input logic             clk,
  input logic             rst,
  key_event_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYC - 1);
  localparam logic [25:0] REP_LAST  = 26'(REPEAT_CYC - 1);

  state_t            state, state_nx;
  logic              key_q;
  logic [25:0]       hold_cnt, rep_cnt;
  logic              rise, hold_term, rep_term;
  logic              ev, press;

  logic              event_q, press_q, long_q, valid_q, overrun_q;
  logic [DATA_W-1:0] data_q;

  assign rise      = bus.key_db & ~key_q;
  assign hold_term = (hold_cnt == HOLD_LAST);
  assign rep_term  = (rep_cnt == REP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = PRESSED;
      PRESSED: begin
        if (!bus.key_db)    state_nx = IDLE;
        else if (hold_term) state_nx = REPEAT;
      end
      REPEAT:  if (!bus.key_db) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Event decode; a release sampled on a terminal-count edge suppresses the event
  always_comb begin
    ev    = 1'b0;
    press = 1'b0;
    case (state)
      IDLE: begin
        ev    = rise;
        press = rise;
      end
      PRESSED: ev = bus.key_db & hold_term;
      REPEAT:  ev = bus.key_db & rep_term;
      default: ;
    endcase
  end

  // Edge detector and hold/repeat counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q    <= 1'b0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      key_q <= bus.key_db;
      case (state)
        IDLE: hold_cnt <= '0;
        PRESSED: begin
          if (bus.key_db) begin
            if (hold_term) rep_cnt  <= '0;
            else           hold_cnt <= hold_cnt + 26'd1;
          end
        end
        REPEAT: begin
          if (bus.key_db) rep_cnt <= rep_term ? '0 : rep_cnt + 26'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and read handshake; a read coinciding with an event
  // consumes the old data, so the new capture stays valid without overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_q   <= 1'b0;
      press_q   <= 1'b0;
      long_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      event_q <= ev;
      press_q <= press;
      long_q  <= (state_nx == REPEAT);
      if (ev) begin
        data_q  <= bus.sw_i;
        valid_q <= 1'b1;
      end else if (bus.rd_i) begin
        valid_q <= 1'b0;
      end
      if (bus.rd_i)          overrun_q <= 1'b0;
      else if (ev & valid_q) overrun_q <= 1'b1;
    end
  end

  assign bus.event_o   = event_q;
  assign bus.press_o   = press_q;
  assign bus.long_o    = long_q;
  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Testbench for key_event_ctrl: reset checks, a vector table for short
// presses and the read/overrun handshake, hand-written long-press and
// asynchronous-reset sequences, and randomized stimulus against a
// cycle-count reference model.
module tb_key_event_ctrl;
  localparam int DW   = 8;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_event_ctrl_if #(.DATA_W(DW)) bus ();

  key_event_ctrl #(
    .DATA_W    (DW),
    .HOLD_CYC  (HOLD),
    .REPEAT_CYC(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: counts edges since the press instead of tracking states
  bit          m_prev, m_active, m_ev, m_pr, m_long, m_valid, m_ovr;
  int          m_n;
  logic [7:0]  m_data;

  task automatic model_reset();
    m_prev = 0; m_active = 0; m_n = 0;
    m_ev = 0; m_pr = 0; m_long = 0; m_valid = 0; m_ovr = 0; m_data = '0;
  endtask

  task automatic model_edge(input bit k, input logic [7:0] s, input bit r);
    bit ev, pr;
    ev = 0; pr = 0;
    if (!k) begin
      m_active = 0;
    end else if (!m_prev) begin
      m_active = 1; m_n = 0; ev = 1; pr = 1;
    end else if (m_active) begin
      m_n++;
      if (m_n >= HOLD && ((m_n - HOLD) % REP) == 0) ev = 1;
    end
    m_long = m_active && (m_n >= HOLD);
    m_prev = k;
    if (r)                m_ovr = 0;
    else if (ev && m_valid) m_ovr = 1;
    if (ev) begin
      m_data = s; m_valid = 1;
    end else if (r) begin
      m_valid = 0;
    end
    m_ev = ev; m_pr = pr;
  endtask

  function automatic logic [15:0] mvec();
    return {3'b000, m_ev, m_pr, m_long, m_valid, m_ovr, m_data};
  endfunction

  function automatic logic [15:0] outs();
    return {3'b000, bus.event_o, bus.press_o, bus.long_o, bus.valid_o,
            bus.overrun_o, bus.data_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit k, input logic [7:0] s, input bit r);
    bus.key_db = k; bus.sw_i = s; bus.rd_i = r;
    @(posedge clk);
    model_edge(k, s, r);
    #1;
  endtask

  // flags = {event, press, long, valid, overrun}
  typedef struct {
    bit         key;
    logic [7:0] sw;
    bit         rd;
    logic [4:0] flags;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit k;
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 5'b11010, 8'hA5};
    tbl[1]  = '{1'b1, 8'hA5, 1'b0, 5'b00010, 8'hA5};
    tbl[2]  = '{1'b1, 8'hA5, 1'b0, 5'b00010, 8'hA5};
    tbl[3]  = '{1'b1, 8'hA5, 1'b0, 5'b00010, 8'hA5};
    tbl[4]  = '{1'b1, 8'hA5, 1'b0, 5'b00010, 8'hA5};
    tbl[5]  = '{1'b0, 8'hA5, 1'b0, 5'b00010, 8'hA5};
    tbl[6]  = '{1'b0, 8'hA5, 1'b1, 5'b00000, 8'hA5};
    tbl[7]  = '{1'b1, 8'h11, 1'b0, 5'b11010, 8'h11};
    tbl[8]  = '{1'b0, 8'h11, 1'b0, 5'b00010, 8'h11};
    tbl[9]  = '{1'b1, 8'h22, 1'b0, 5'b11011, 8'h22};
    tbl[10] = '{1'b0, 8'h22, 1'b0, 5'b00011, 8'h22};
    tbl[11] = '{1'b0, 8'h22, 1'b1, 5'b00000, 8'h22};
    tbl[12] = '{1'b1, 8'h33, 1'b0, 5'b11010, 8'h33};
    tbl[13] = '{1'b0, 8'h33, 1'b0, 5'b00010, 8'h33};
    tbl[14] = '{1'b1, 8'h44, 1'b1, 5'b11010, 8'h44};
    tbl[15] = '{1'b0, 8'h44, 1'b0, 5'b00010, 8'h44};
    tbl[16] = '{1'b1, 8'h55, 1'b0, 5'b11011, 8'h55};
    tbl[17] = '{1'b0, 8'h55, 1'b1, 5'b00000, 8'h55};
    tbl[18] = '{1'b0, 8'h55, 1'b1, 5'b00000, 8'h55};

    // Reset with key low and switches all ones
    rst = 1'b1; bus.key_db = 1'b0; bus.sw_i = 8'hFF; bus.rd_i = 1'b0;
    model_reset();
    #1;
    check("reset outputs", outs(), 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'hFF, 1'b0);
      check($sformatf("post-reset idle %0d", i), outs(), 16'h0000);
    end

    // Short press, overrun, read handshake, simultaneous read+event
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].key, tbl[i].sw, tbl[i].rd);
      check($sformatf("vector %0d", i), outs(), {3'b000, tbl[i].flags, tbl[i].data});
    end

    // Long press: 20 edges high, sw incrementing, release lands on a terminal count
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b0);
      check($sformatf("long event %0d", i), bus.event_o,
            (i == 0 || i == 8 || i == 12 || i == 16) ? 1 : 0);
      check($sformatf("long press %0d", i), bus.press_o, (i == 0) ? 1 : 0);
      check($sformatf("long long %0d", i), bus.long_o, (i >= 8) ? 1 : 0);
    end
    step(1'b0, 8'h74, 1'b0);
    check("release no event", bus.event_o, 0);
    check("release long low", bus.long_o, 0);
    check("long data", bus.data_o, 8'h70);
    check("long overrun", bus.overrun_o, 1);
    step(1'b0, 8'h00, 1'b1);
    check("long read clears", {bus.valid_o, bus.overrun_o}, 2'b00);

    // Asynchronous reset in REPEAT with key held
    for (int i = 0; i < 10; i++) step(1'b1, 8'h5A, 1'b0);
    check("pre-reset long", bus.long_o, 1);
    #2 rst = 1'b1;
    #1 check("async reset outputs", outs(), 16'h0000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h99, 1'b0);
    check("press after reset", outs(), {3'b000, 5'b11010, 8'h99});
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'h99, 1'b0);
      check($sformatf("reset long %0d", i), bus.long_o, (i >= 8) ? 1 : 0);
    end

    // Randomized run against the reference model
    step(1'b0, 8'h00, 1'b1);
    k = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) k = ~k;
      step(k, 8'($urandom), ($urandom_range(0, 5) == 0));
      check($sformatf("random %0d", i), outs(), mvec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
